vend_ctrl: RTL



---
 rtl/vend_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/vend_ctrl.sv
// Vending machine sequencer: coin credit, vend pulse, dime-first change payout.
// Optional refund-on-cancel path enabled by defining VEND_CANCEL_EN.
module vend_ctrl #(
  parameter int PRICE = 20
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       nickle_i,
  input  logic       dime_i,
  input  logic       quarter_i,
  input  logic       cancel_i,
  output logic [5:0] deposit_o,
  output logic [5:0] change_o,
  output logic       busy_o,
  output logic       soda_o,
  output logic       nickle_o,
  output logic       dime_o,
  output logic       reject_o
);

  localparam logic [5:0] PRICE_W = 6'(PRICE);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VEND    = 2'd1,
    CHANGE  = 2'd2
`ifdef VEND_CANCEL_EN
    , REFUND = 2'd3
`endif
  } state_t;

  state_t     state, state_nx;
  logic [5:0] deposit_nx, change_nx, coin_val, sum;
  logic       coin_any, cancel_take, paying_nx;

  assign coin_any = nickle_i | dime_i | quarter_i;

  // Nickel has priority over dime, dime over quarter; losers are dropped.
  always_comb begin
    coin_val = '0;
    if (nickle_i)       coin_val = 6'd5;
    else if (dime_i)    coin_val = 6'd10;
    else if (quarter_i) coin_val = 6'd25;
  end

`ifdef VEND_CANCEL_EN
  assign cancel_take = (state == COLLECT) && cancel_i && (deposit_o != '0);
`else
  logic unused_cancel;
  assign unused_cancel = cancel_i;
  assign cancel_take   = 1'b0;
`endif

  assign sum      = deposit_o + coin_val;
  assign reject_o = coin_any & (busy_o | cancel_take);

  always_comb begin
    state_nx   = state;
    deposit_nx = deposit_o;
    change_nx  = change_o;
    case (state)
      COLLECT: begin
        if (cancel_take) begin
          change_nx  = deposit_o;
          deposit_nx = '0;
`ifdef VEND_CANCEL_EN
          state_nx   = REFUND;
`endif
        end else if (coin_any) begin
          if (sum < PRICE_W) begin
            deposit_nx = sum;
          end else begin
            change_nx  = sum - PRICE_W;
            deposit_nx = '0;
            state_nx   = VEND;
          end
        end
      end
      VEND: state_nx = (change_o != '0) ? CHANGE : COLLECT;
`ifdef VEND_CANCEL_EN
      REFUND,
`endif
      CHANGE: begin
        change_nx = (change_o >= 6'd10) ? change_o - 6'd10 : change_o - 6'd5;
        if (change_nx == '0) state_nx = COLLECT;
      end
      default: state_nx = COLLECT;
    endcase
  end

`ifdef VEND_CANCEL_EN
  assign paying_nx = (state_nx == CHANGE) || (state_nx == REFUND);
`else
  assign paying_nx = (state_nx == CHANGE);
`endif

  // Moore outputs are registered by decoding the next state/change, so they
  // track the state and change_o registers exactly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= COLLECT;
      deposit_o <= '0;
      change_o  <= '0;
      busy_o    <= 1'b0;
      soda_o    <= 1'b0;
      nickle_o  <= 1'b0;
      dime_o    <= 1'b0;
    end else begin
      state     <= state_nx;
      deposit_o <= deposit_nx;
      change_o  <= change_nx;
      busy_o    <= (state_nx != COLLECT);
      soda_o    <= (state_nx == VEND);
      dime_o    <= paying_nx && (change_nx >= 6'd10);
      nickle_o  <= paying_nx && (change_nx < 6'd10);
    end
  end

endmodule
